// File: rtl/ieee754_div_seq_if.sv
// Handshake and operand/result bundle for the sequential IEEE-754 divider.
// master drives operands and consumes results; slave is the divider.
interface ieee754_div_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         div_by_zero;
  logic         invalid;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, div_by_zero, invalid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, underflow, div_by_zero, invalid
  );
endinterface

// File: rtl/ieee754_div_seq.sv
// Multi-cycle IEEE-754 divider, restoring, one quotient bit per clock, fixed latency.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the quotient is truncated.
//
// state  | meaning
// IDLE   | ready, operands captured on accept
// DIVIDE | one unpack cycle, then M+3 restoring iterations
// ROUND  | normalise, round, apply specials/overflow/underflow
// DONE   | result held until out_ready
module ieee754_div_seq #(
  parameter int N = 32,
  parameter int M = 23,
  parameter int E = N - M - 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ieee754_div_seq_if.slave  bus
);
  localparam int BIAS = 2**(E-1) - 1;
  localparam int QW   = M + 3;
  localparam int RW   = M + 2;
  localparam int EW   = E + 2;
  localparam int CW   = $clog2(M + 5);
  localparam logic [CW-1:0] LOAD    = CW'(M + 4);
  localparam logic [EW-1:0] EXP_MAX = EW'(2**E - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   a_q, b_q;
  logic [RW-1:0]  rem_q;
  logic [QW-1:0]  quo_q;
  logic [EW-1:0]  exp_q;
  logic           sign_q, spec_q, spec_inv_q, spec_dbz_q;
  logic [N-1:0]   spec_res_q;
  logic [N-1:0]   result_q;
  logic           ovf_q, unf_q, dbz_q, inv_q;

  logic [E-1:0]   ea, eb;
  logic [M-1:0]   ma, mb;
  logic           a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_d;
  logic           spec_d, spec_inv_d, spec_dbz_d;
  logic [N-1:0]   spec_res_d;
  logic [RW-1:0]  div_ext, rem_d;
  logic           ge;

  assign ea     = a_q[N-2:M];
  assign eb     = b_q[N-2:M];
  assign ma     = a_q[M-1:0];
  assign mb     = b_q[M-1:0];
  assign sign_d = a_q[N-1] ^ b_q[N-1];
  // Subnormal inputs collapse to zero regardless of their fraction.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);

  always_comb begin
    spec_d     = 1'b1;
    spec_inv_d = 1'b0;
    spec_dbz_d = 1'b0;
    spec_res_d = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_inv_d = 1'b1;
      spec_res_d = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    end else if (a_inf) begin
      spec_res_d = {sign_d, {E{1'b1}}, {M{1'b0}}};
    end else if (b_zero) begin
      spec_dbz_d = 1'b1;
      spec_res_d = {sign_d, {E{1'b1}}, {M{1'b0}}};
    end else if (a_zero || b_inf) begin
      spec_res_d = {sign_d, {(N-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  assign div_ext = {1'b0, 1'b1, mb};
  assign ge      = (rem_q >= div_ext);
  assign rem_d   = ge ? {rem_q[RW-2:0] - div_ext[RW-2:0], 1'b0} : {rem_q[RW-2:0], 1'b0};

  logic [QW-1:0]  qn;
  logic [EW-1:0]  exp_n, exp_r;
  logic [M:0]     mant;
  logic [M+1:0]   mant_r;
  logic           rnd_up, ovf_d, unf_d;
  logic [N-1:0]   res_d;

  always_comb begin
    qn     = quo_q[QW-1] ? quo_q : {quo_q[QW-2:0], 1'b0};
    exp_n  = quo_q[QW-1] ? exp_q : exp_q - EW'(1);
    mant   = qn[QW-1:2];
`ifdef ROUND_NEAREST_EN
    rnd_up = qn[1] & (qn[0] | (|rem_q) | mant[0]);
`else
    rnd_up = 1'b0;
`endif
    mant_r = {1'b0, mant} + (M+2)'(rnd_up);
    // A carry out leaves the fraction all-zero, so only the exponent moves.
    exp_r  = exp_n + EW'(mant_r[M+1]);
    ovf_d  = !exp_r[EW-1] && (exp_r >= EXP_MAX);
    unf_d  = exp_r[EW-1] || (exp_r == '0);
    if (spec_q)     res_d = spec_res_q;
    else if (ovf_d) res_d = {sign_q, {E{1'b1}}, {M{1'b0}}};
    else if (unf_d) res_d = {sign_q, {(N-1){1'b0}}};
    else            res_d = {sign_q, exp_r[E-1:0], mant_r[M-1:0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = DIVIDE;
      DIVIDE:  if (cnt_q == CW'(1)) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0; a_q <= '0; b_q <= '0; rem_q <= '0; quo_q <= '0; exp_q <= '0;
      sign_q <= 1'b0; spec_q <= 1'b0; spec_inv_q <= 1'b0; spec_dbz_q <= 1'b0;
      spec_res_q <= '0; result_q <= '0;
      ovf_q <= 1'b0; unf_q <= 1'b0; dbz_q <= 1'b0; inv_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q   <= bus.a;
          b_q   <= bus.b;
          cnt_q <= LOAD;
        end
        DIVIDE: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == LOAD) begin
            rem_q      <= {1'b0, 1'b1, ma};
            quo_q      <= '0;
            exp_q      <= EW'(ea) - EW'(eb) + EW'(BIAS);
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_inv_q <= spec_inv_d;
            spec_dbz_q <= spec_dbz_d;
            spec_res_q <= spec_res_d;
          end else begin
            rem_q <= rem_d;
            quo_q <= {quo_q[QW-2:0], ge};
          end
        end
        ROUND: begin
          result_q <= res_d;
          ovf_q    <= !spec_q && ovf_d;
          unf_q    <= !spec_q && !ovf_d && unf_d;
          inv_q    <= spec_q && spec_inv_q;
          dbz_q    <= spec_q && spec_dbz_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.result      = result_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.invalid     = inv_q;
endmodule

// File: tb/tb_ieee754_div_seq.sv
// Directed bench for ieee754_div_seq: literal vectors plus an arithmetic reference
// model checked every cycle the result is presented.
module tb_ieee754_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [35:0] cur_exp = '0;   // {invalid, div_by_zero, overflow, underflow, result}

  ieee754_div_seq_if #(.N(32)) bus ();
  ieee754_div_seq #(.N(32), .M(23)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ea, eb;
    logic [22:0] ma, mb;
    logic s, az, bz, ai, bi, an, bn;
    longint unsigned num, den, q, r, mant;
    int e;
    ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
    s  = a[31] ^ b[31];
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 8'hFF) && (ma == 0); bi = (eb == 8'hFF) && (mb == 0);
    an = (ea == 8'hFF) && (ma != 0); bn = (eb == 8'hFF) && (mb != 0);
    if (an || bn || (az && bz) || (ai && bi)) return {4'b1000, 32'h7FC00000};
    if (ai) return {4'b0000, s, 8'hFF, 23'h0};
    if (bz) return {4'b0100, s, 8'hFF, 23'h0};
    if (az || bi) return {4'b0000, s, 31'h0};
    num = (longint'(8388608) + longint'(ma)) << 25;
    den = longint'(8388608) + longint'(mb);
    q = num / den;
    r = num % den;
    e = int'(ea) - int'(eb) + 127;
    if (q < (64'd1 << 25)) begin q = q * 2; e = e - 1; end
    mant = q >> 2;
`ifdef ROUND_NEAREST_EN
    if (q[1] && (q[0] || (r != 0) || mant[0])) mant = mant + 1;
`endif
    if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
    if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0001, s, 31'h0};
    return {4'b0000, s, 8'(e), mant[22:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference check on every presented result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      chk("model", {28'h0, bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow, bus.result},
          {28'h0, cur_exp});
      chk("ready_while_valid", {63'h0, bus.in_ready}, 64'h0);
    end
  end

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    cur_exp = model(a, b);
    @(negedge clk);
    chk("idle_ready", {63'h0, bus.in_ready}, 64'h1);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = ~a; bus.b = ~b;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res_lit, input logic [3:0] flg_lit, input int hold);
    int n;
    bit got;
    accept(a, b);
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.out_valid) got = 1;
    end
    chk("latency", 64'(n), 64'd28);
    chk("result", {32'h0, bus.result}, {32'h0, res_lit});
    chk("flags", {60'h0, bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow}, {60'h0, flg_lit});
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000;
      @(posedge clk); #1;
      chk("hold_valid", {63'h0, bus.out_valid}, 64'h1);
      chk("hold_result", {32'h0, bus.result}, {32'h0, res_lit});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("drain_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("no_bypass", {63'h0, bus.in_ready}, 64'h1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("rst_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_result", {32'h0, bus.result}, 64'h0);
    chk("rst_flags", {60'h0, bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow}, 64'h0);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);
`ifdef ROUND_NEAREST_EN
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 0);
    run_op(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000, 0);
`else
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 0);
    run_op(32'h40000000, 32'h40400000, 32'h3F2AAAAA, 4'b0000, 0);
`endif
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
    run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 0);
    run_op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 0);
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 5);
    run_op(32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 0);
    run_op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 0);
    run_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 0);
    run_op(32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 0);
    run_op(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 0);
    run_op(32'h00400000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
    run_op(32'hBF800000, 32'hBF800000, 32'h3F800000, 4'b0000, 2);

    // Abort mid-divide, then confirm nothing emerges and the next op is clean.
    accept(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("abort_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("abort_result", {32'h0, bus.result}, 64'h0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("abort_quiet", {63'h0, seen}, 64'h0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
